// File: rtl/chaos_keystream_xor.sv
// Chaos keystream XOR stage.
// Captures the four 384-bit generator keys once the done flag has been seen
// on two consecutive edges, slices them into 48 32-bit keystream words and
// XORs one word onto each accepted word of a valid/ready stream. The same
// operation encrypts and decrypts.
module chaos_keystream_xor #(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [383:0] k1,
  input  logic [383:0] k2,
  input  logic [383:0] k3,
  input  logic [383:0] k4,
  input  logic         flag,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         keys_loaded,
  output logic [5:0]   word_idx,
  output logic         exhausted
);

  localparam logic [5:0] LastWord = 6'd47;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StDone
  } state_e;

  state_e          state;
  // Keys concatenated k1..k4, so word w sits at bits [1535-32*w -: 32].
  logic [1535:0]   key_reg;
  logic [31:0]     key_word;
  logic            accept;

  // Current keystream word, selected by the next-word index.
  always_comb begin
    key_word = key_reg[11'd1535 - {word_idx, 5'd0} -: 32];
  end

  // Accept only in RUN with a free (or draining) output register. Reset and a
  // dropped flag both discard the cycle, so no upstream word is lost silently.
  always_comb begin
    in_ready = !rst && flag && (state == StRun) && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  // Control FSM, key capture and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      key_reg     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      keys_loaded <= 1'b0;
      word_idx    <= '0;
      exhausted   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (flag) state <= StArm;
        end

        // One-cycle settle guard: flag must still be high before capture.
        StArm: begin
          if (flag) begin
            key_reg     <= {k1, k2, k3, k4};
            keys_loaded <= 1'b1;
            word_idx    <= '0;
            state       <= StRun;
          end else begin
            state <= StIdle;
          end
        end

        StRun, StDone: begin
          if (!flag) begin
            // Generator restarted: drop everything and wait for a new flag.
            state       <= StIdle;
            out_valid   <= 1'b0;
            keys_loaded <= 1'b0;
            exhausted   <= 1'b0;
            word_idx    <= '0;
          end else if (accept) begin
            out_data  <= in_data ^ key_word;
            out_valid <= 1'b1;
            if (word_idx == LastWord) begin
              if (WRAP_EN) begin
                word_idx <= '0;
              end else begin
                state     <= StDone;
                exhausted <= 1'b1;
              end
            end else begin
              word_idx <= word_idx + 6'd1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_chaos_keystream_xor.sv
// Directed bench for chaos_keystream_xor. Two instances share the stimulus:
// dut1 wraps the word index, dut0 stops after word 47.
module tb_chaos_keystream_xor;

  logic          clk = 1'b0;
  logic          rst;
  logic [1535:0] key_all;
  logic [383:0]  k1, k2, k3, k4;
  logic          flag;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          out_ready;

  logic          in_ready1, out_valid1, keys_loaded1, exhausted1;
  logic [31:0]   out_data1;
  logic [5:0]    word_idx1;
  logic          in_ready0, out_valid0, keys_loaded0, exhausted0;
  logic [31:0]   out_data0;
  logic [5:0]    word_idx0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign k1 = key_all[1535:1152];
  assign k2 = key_all[1151:768];
  assign k3 = key_all[767:384];
  assign k4 = key_all[383:0];

  chaos_keystream_xor #(.WRAP_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .k1(k1), .k2(k2), .k3(k3), .k4(k4), .flag(flag),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .keys_loaded(keys_loaded1), .word_idx(word_idx1), .exhausted(exhausted1)
  );

  chaos_keystream_xor #(.WRAP_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .k1(k1), .k2(k2), .k3(k3), .k4(k4), .flag(flag),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .keys_loaded(keys_loaded0), .word_idx(word_idx0), .exhausted(exhausted0)
  );

  // Key image whose word w equals {hi, 24'(w)}.
  function automatic logic [1535:0] mk_keys(input logic [7:0] hi);
    logic [1535:0] f;
    f = '0;
    for (int w = 0; w < 48; w++) f[1535 - 32*w -: 32] = {hi, 24'(w)};
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] d;

    rst = 1'b1; flag = 1'b0; in_valid = 1'b1; in_data = 32'h12345678;
    out_ready = 1'b1; key_all = mk_keys(8'hA5);
    tick();
    check("rst_out_data", out_data1, 0);
    check("rst_out_valid", out_valid1, 0);
    check("rst_keys_loaded", keys_loaded1, 0);
    check("rst_word_idx", word_idx1, 0);
    check("rst_exhausted", exhausted0, 0);
    check("rst_in_ready", in_ready1, 0);
    rst = 1'b0;

    // 1: flag low, input offered but never taken.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_in_ready", in_ready1, 0);
      check("idle_out_valid", out_valid1, 0);
      check("idle_keys_loaded", keys_loaded1, 0);
      check("idle_word_idx", word_idx1, 0);
    end

    // 2: arm, capture, then a full 48-word stream.
    flag = 1'b1; in_data = 32'hDEADBEEF;
    tick();
    check("arm_keys_loaded", keys_loaded1, 0);
    check("arm_in_ready", in_ready1, 0);
    tick();
    check("run_keys_loaded", keys_loaded1, 1);
    check("run_out_valid", out_valid1, 0);
    check("run_in_ready", in_ready1, 1);
    check("run_in_ready0", in_ready0, 1);
    for (int w = 0; w < 48; w++) begin
      d = (w == 5) ? 32'hFFFFFFFF : 32'h0;
      in_data = d;
      tick();
      check("stream_valid", out_valid1, 1);
      check("stream_data", out_data1, (32'hA5000000 | 32'(w)) ^ d);
      check("stream_data0", out_data0, (32'hA5000000 | 32'(w)) ^ d);
      if (w == 5) check("word5_data", out_data1, 32'h5AFFFFFA);
      if (w < 47) check("stream_idx", word_idx1, w + 1);
    end

    // 4: word limit.
    check("wrap_idx_after48", word_idx1, 0);
    check("nowrap_exhausted", exhausted0, 1);
    check("nowrap_idx", word_idx0, 47);
    check("nowrap_in_ready", in_ready0, 0);
    check("nowrap_last_valid", out_valid0, 1);
    check("nowrap_last_data", out_data0, 32'hA500002F);
    in_data = 32'h0;
    tick();
    check("wrap_data49", out_data1, 32'hA5000000);
    check("wrap_idx49", word_idx1, 1);
    check("nowrap_drained", out_valid0, 0);
    check("nowrap_still_exh", exhausted0, 1);

    // 3: backpressure on dut1.
    out_ready = 1'b0; in_data = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", in_ready1, 0);
      tick();
      check("bp_data", out_data1, 32'hA5000000);
      check("bp_valid", out_valid1, 1);
      check("bp_idx", word_idx1, 1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready1, 1);
    tick();
    check("bp_resume_data", out_data1, 32'hB4111110);
    check("bp_resume_idx", word_idx1, 2);
    for (int w = 2; w < 10; w++) begin
      in_data = 32'h0;
      tick();
      check("pre_restart_data", out_data1, 32'hA5000000 | 32'(w));
    end
    check("pre_restart_idx", word_idx1, 10);

    // 5: generator restart with new keys.
    flag = 1'b0;
    tick();
    check("restart_valid", out_valid1, 0);
    check("restart_keys_loaded", keys_loaded1, 0);
    check("restart_idx", word_idx1, 0);
    check("restart_in_ready", in_ready1, 0);
    check("restart_exh0", exhausted0, 0);
    key_all = mk_keys(8'h5A);
    flag = 1'b1;
    tick();
    check("rearm_keys_loaded", keys_loaded1, 0);
    tick();
    check("rearm_keys_loaded2", keys_loaded1, 1);
    key_all = mk_keys(8'hA5);  // live keys must be ignored from here on
    tick();
    check("newkey_w0", out_data1, 32'h5A000000);
    check("newkey_w0_dut0", out_data0, 32'h5A000000);
    tick();
    check("newkey_w1", out_data1, 32'h5A000001);
    for (int w = 2; w < 20; w++) tick();
    check("mid_idx", word_idx1, 20);
    check("mid_valid", out_valid1, 1);
    check("mid_data", out_data1, 32'h5A000013);

    // 6: rst pulse mid-stream with flag still high.
    rst = 1'b1;
    #1 check("rst_pulse_in_ready", in_ready1, 0);
    tick();
    check("rst2_out_data", out_data1, 0);
    check("rst2_out_valid", out_valid1, 0);
    check("rst2_keys_loaded", keys_loaded1, 0);
    check("rst2_word_idx", word_idx1, 0);
    rst = 1'b0;
    tick();
    check("rst2_arm_keys", keys_loaded1, 0);
    tick();
    check("rst2_run_keys", keys_loaded1, 1);
    in_data = 32'h0000FFFF;
    tick();
    check("rst2_first_data", out_data1, 32'hA500FFFF);
    check("rst2_first_idx", word_idx1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chaos_keystream_xor.md
Name: chaos_keystream_xor

Overview:
- Consumer side of the chaos key generator. Takes the generator's four 384-bit keys (k1..k4) and its done flag.
- Once the flag is stable, captures all keys and splits them into 48 32-bit keystream words.
- XORs the keystream word-by-word onto a valid/ready data stream. Encryption and decryption are the same operation.
- Sits between the key generator and the data path.

Parameters:
- WRAP_EN, 1: 1 = word index wraps 47->0 and streaming continues; 0 = stop after word 47 and assert exhausted.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- k1  in  384  key 1 from generator
- k2  in  384  key 2 from generator
- k3  in  384  key 3 from generator
- k4  in  384  key 4 from generator
- flag  in  1  generator done; level, stays high until generator reset
- in_data  in  32  plaintext/ciphertext word
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  32  in_data XOR keystream word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- keys_loaded  out  1  keys captured, block in RUN or DONE
- word_idx  out  6  index of next keystream word, 0..47
- exhausted  out  1  WRAP_EN=0 and all 48 words used

Behaviour:
- Reset: one clock, synchronous, active-high. On the reset edge: state=IDLE, out_data=0, out_valid=0, keys_loaded=0, word_idx=0, exhausted=0. in_ready is combinational and is 0 during and after reset. Reset mid-stream discards any pending output.
- Key word order: word 0 = k1[383:352] ... word 11 = k1[31:0], word 12 = k2[383:352] ... word 47 = k4[31:0]. Word w = key(w/12)[383-32*(w%12) -: 32].
- Keys are captured into internal registers. Live k1..k4 are ignored after capture.
- FSM IDLE:
  - flag=1 at edge -> ARM.
  - else stay.
- FSM ARM (one-cycle settle guard):
  - flag=1 -> capture k1..k4, keys_loaded<=1, word_idx<=0 -> RUN.
  - flag=0 -> IDLE.
- FSM RUN:
  - in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready: out_data <= in_data ^ word[word_idx], out_valid<=1, word_idx increments.
  - At word_idx=47 with WRAP_EN=1: word_idx<=0.
  - At word_idx=47 with WRAP_EN=0: ->DONE, exhausted<=1, word_idx stays 47.
- FSM DONE:
  - in_ready=0.
  - Pending output still drains through normal handshake.
  - Leaves DONE only on rst or flag=0.
- Output register:
  - Latency is 1 cycle from input accept to out_valid.
  - out_valid && out_ready with no new accept -> out_valid<=0.
  - Simultaneous drain and accept -> out_valid stays 1 with new data.
  - While out_valid && !out_ready: out_data, out_valid and word_idx hold; in_ready=0.
  - Full throughput is one word per cycle.
- flag=0 seen in RUN or DONE (generator reset): next edge -> IDLE. Also clears out_valid, keys_loaded, exhausted and word_idx. Pending output is dropped. Re-arming requires flag high again (IDLE->ARM->RUN) and recaptures keys.
- in_ready=0 in IDLE and ARM. in_valid there is ignored and no data is consumed.
- Priority: rst > flag low > handshake.

Test Plan:
- Keys for all tests: word w = 0xA5000000|w.
1. Reset with flag=0: 20 cycles of in_valid=1 -> in_ready=0, out_valid=0, keys_loaded=0, word_idx=0 throughout.
2. Startup and full stream: raise flag -> keys_loaded=1 and in_ready=1 two edges later. Then 48 words of 0x00000000, in_valid=1, out_ready=1 -> out_data = 0xA5000000..0xA500002F on consecutive cycles, each 1 cycle after accept. Input 0xFFFFFFFF at word 5 -> out 0x5AFFFFFA.
3. Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data, word_idx stable, in_ready=0. Then out_ready=1 -> stream resumes with no loss or duplication.
4. Word limit:
   - WRAP_EN=0: after 48 accepts -> exhausted=1, in_ready=0, last output drains.
   - WRAP_EN=1: 49th word XORs 0xA5000000 and word_idx=1 after it.
5. Generator restart: drop flag at word_idx=10 with out_valid=1 -> next edge IDLE, out_valid=0, keys_loaded=0, word_idx=0. Reassert flag with new keys -> first output uses new word 0.
6. rst pulse mid-stream (word_idx=20, out_valid=1, flag=1) -> next edge all outputs at reset values. Block re-arms via ARM because flag is still high.
